// File: rtl/sne_cfg_seq_pkg.sv
// rtl/sne_cfg_seq_pkg.sv - shared types and defaults for the SNE APB configuration sequencer
package sne_cfg_seq_pkg;

  localparam int unsigned CFG_ADDR_WIDTH     = 32;
  localparam int unsigned CFG_DATA_WIDTH     = 32;
  localparam int unsigned CFG_FIFO_DEPTH     = 8;
  localparam int unsigned CFG_TIMEOUT_CYCLES = 1024;
  localparam int unsigned CFG_POLL_MAX       = 256;

  typedef enum logic [2:0] {
    OP_WR   = 3'd0,
    OP_RD   = 3'd1,
    OP_SET  = 3'd2,
    OP_CLR  = 3'd3,
    OP_POLL = 3'd4
  } cfg_op_e;

  typedef struct packed {
    cfg_op_e                   op;
    logic [CFG_ADDR_WIDTH-1:0] addr;
    logic [CFG_DATA_WIDTH-1:0] data;
  } cfg_cmd_t;

  // ST_GAP is the single psel=0 cycle between the phases of SET/CLR/POLL
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_RESP   = 3'd4
  } cfg_seq_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/sne_cfg_cmd_fifo.sv
// rtl/sne_cfg_cmd_fifo.sv - synchronous command FIFO with push/pop/clear and full/empty flags
module sne_cfg_cmd_fifo
  import sne_cfg_seq_pkg::*;
#(
  parameter int unsigned DEPTH = CFG_FIFO_DEPTH,
  parameter type         T     = cfg_cmd_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign rdata_o = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sne_apb_cfg_sequencer.sv
// rtl/sne_apb_cfg_sequencer.sv - APB master executing queued write/read/set/clear/poll commands
module sne_apb_cfg_sequencer
  import sne_cfg_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = CFG_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = CFG_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH     = CFG_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = CFG_TIMEOUT_CYCLES,
  parameter int unsigned POLL_MAX       = CFG_POLL_MAX
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef struct packed {
    cfg_op_e               op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  cfg_seq_state_e        state_q, state_d;
  cmd_t                  cmd_q, cmd_d, fifo_head, fifo_wdata;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic                  wr_phase_q, wr_phase_d, rsp_err_q, rsp_err_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [PW-1:0]         poll_q, poll_d;
  logic [15:0]           err_cnt_q;
  logic                  fifo_full, fifo_empty, have_cmd, pop, apb_active;

  assign fifo_wdata = '{op: cfg_op_e'(cmd_op_i), addr: cmd_addr_i, data: cmd_data_i};

  sne_cfg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (cmd_valid_i),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A flush in progress hides the head so it is never launched
  assign have_cmd = !fifo_empty && !clear_i;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    wr_phase_d = wr_phase_q;
    tmo_d      = tmo_q;
    poll_d     = poll_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE:  pop = have_cmd;
      ST_SETUP: begin
        state_d = ST_ACCESS;
        tmo_d   = '0;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          if (wr_phase_q) begin
            rsp_data_d = wdata_q;
            rsp_err_d  = pslverr_i;
            state_d    = ST_RESP;
          end else if (pslverr_i) begin
            rsp_data_d = prdata_i;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end else begin
            case (cmd_q.op)
              OP_SET: begin
                wdata_d    = prdata_i | cmd_q.data;
                wr_phase_d = 1'b1;
                state_d    = ST_GAP;
              end
              OP_CLR: begin
                wdata_d    = prdata_i & ~cmd_q.data;
                wr_phase_d = 1'b1;
                state_d    = ST_GAP;
              end
              OP_POLL: begin
                if ((prdata_i & cmd_q.data) != '0) begin
                  rsp_data_d = prdata_i;
                  state_d    = ST_RESP;
                end else if (poll_q == PW'(POLL_MAX - 1)) begin
                  rsp_data_d = prdata_i;
                  rsp_err_d  = 1'b1;
                  state_d    = ST_RESP;
                end else begin
                  poll_d  = poll_q + PW'(1);
                  state_d = ST_GAP;
                end
              end
              default: begin
                rsp_data_d = prdata_i;
                state_d    = ST_RESP;
              end
            endcase
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP:  state_d = ST_SETUP;
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
          pop     = have_cmd;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Launching a command overrides the state choice above; illegal opcodes respond without APB traffic
    if (pop) begin
      cmd_d      = fifo_head;
      wdata_d    = fifo_head.data;
      wr_phase_d = (fifo_head.op == OP_WR);
      poll_d     = '0;
      rsp_data_d = '0;
      rsp_err_d  = !op_is_legal(fifo_head.op);
      state_d    = op_is_legal(fifo_head.op) ? ST_SETUP : ST_RESP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      wdata_q    <= '0;
      wr_phase_q <= 1'b0;
      tmo_q      <= '0;
      poll_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      wr_phase_q <= wr_phase_d;
      tmo_q      <= tmo_d;
      poll_q     <= poll_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (state_q == ST_RESP && rsp_ready_i && rsp_err_q && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign apb_active  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign psel_o      = apb_active;
  assign penable_o   = (state_q == ST_ACCESS);
  assign paddr_o     = apb_active ? cmd_q.addr : '0;
  assign pwrite_o    = apb_active && wr_phase_q;
  assign pwdata_o    = (apb_active && wr_phase_q) ? wdata_q : '0;
  assign cmd_ready_o = !fifo_full;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rsp_valid_o ? rsp_data_q : '0;
  assign rsp_err_o   = rsp_valid_o && rsp_err_q;
  assign busy_o      = !fifo_empty || (state_q != ST_IDLE);
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_sne_apb_cfg_sequencer.sv
// tb/tb_sne_apb_cfg_sequencer.sv - self-checking bench for sne_apb_cfg_sequencer
`timescale 1ns/1ps
module tb_sne_apb_cfg_sequencer;

  logic        clk_i, rst_ni, clear_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [31:0] cmd_addr_i, cmd_data_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic [31:0] rsp_data_o;
  logic [15:0] err_cnt_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        pwrite_o, psel_o, penable_o, pready_i, pslverr_i;

  sne_apb_cfg_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16), .POLL_MAX(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o), .err_cnt_o(err_cnt_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .psel_o(psel_o),
    .penable_o(penable_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] data; logic err; } rsp_t;
  typedef struct packed { logic [7:0] waits; logic [31:0] rdata; logic err; } slv_t;
  typedef struct packed { logic w; logic [31:0] addr; logic [31:0] wdata; } xfer_t;
  typedef struct packed {
    logic [2:0]        op;
    logic [31:0]       addr;
    logic [31:0]       data;
    logic [7:0]        waits;
    logic [2:0]        nslv;
    logic [3:0][31:0]  srd;
    logic [3:0]        serr;
    logic [31:0]       exp_data;
    logic              exp_err;
    logic [2:0]        exp_xfers;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  int    err_exp = 0;
  int    pen_cycles = 0;
  rsp_t  exp_q[$];
  slv_t  slv_q[$];
  xfer_t xfer_log[$];

  // APB slave: scripted wait states, read data and pslverr per transfer
  slv_t sl_cur;
  bit   sl_active = 0;
  int   sl_wcnt = 0;
  always @(negedge clk_i) begin
    if (psel_o && penable_o) begin
      pen_cycles++;
      if (!sl_active) begin
        sl_active = 1;
        sl_wcnt = 0;
        if (slv_q.size() > 0) sl_cur = slv_q.pop_front();
        else sl_cur = '0;
      end
      if (sl_wcnt >= int'(sl_cur.waits)) begin
        pready_i = 1'b1;
        prdata_i = sl_cur.rdata;
        pslverr_i = sl_cur.err;
        xfer_log.push_back('{w: pwrite_o, addr: paddr_o, wdata: pwdata_o});
      end else begin
        pready_i = 1'b0;
        prdata_i = '0;
        pslverr_i = 1'b0;
      end
      sl_wcnt++;
    end else begin
      sl_active = 0;
      pready_i = 1'b0;
      prdata_i = '0;
      pslverr_i = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input rsp_t e);
    bit ok;
    ok = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = addr; cmd_data_i = data;
    for (int c = 0; c < 50 && !ok; c++) begin
      ok = cmd_ready_o;
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    if (ok) exp_q.push_back(e);
    else check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic collect(input int budget);
    bit   got;
    rsp_t e;
    got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk_i);
      got = rsp_valid_o;
    end
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("rsp_data", rsp_data_o, e.data);
    check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    if (e.err) err_exp++;
    check("err_cnt", {16'd0, err_cnt_o}, err_exp);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                              input logic [7:0] waits, input logic [2:0] nslv,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3,
                              input logic [3:0] serr, input logic [31:0] ed, input logic ee,
                              input logic [2:0] ex);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.waits = waits; v.nslv = nslv;
    v.srd = {r3, r2, r1, r0}; v.serr = serr;
    v.exp_data = ed; v.exp_err = ee; v.exp_xfers = ex;
    return v;
  endfunction

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    int   acc;
    bit   ok;
    bit   is_wr;

    // op addr data waits nslv r0..r3 serr | exp_data exp_err exp_xfers
    vecs[0]  = mk(3'd0, 32'h40, 32'h1234, 8'd0, 3'd0, 0, 0, 0, 0, 4'b0000, 32'h1234, 1'b0, 3'd1);
    vecs[1]  = mk(3'd1, 32'h44, 32'h0, 8'd1, 3'd1, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 32'hDEADBEEF, 1'b0, 3'd1);
    vecs[2]  = mk(3'd1, 32'h48, 32'h0, 8'd0, 3'd1, 32'hBAD0, 0, 0, 0, 4'b0001, 32'hBAD0, 1'b1, 3'd1);
    vecs[3]  = mk(3'd2, 32'h80, 32'h10, 8'd2, 3'd2, 32'h3, 0, 0, 0, 4'b0000, 32'h13, 1'b0, 3'd2);
    vecs[4]  = mk(3'd3, 32'h84, 32'h2, 8'd0, 3'd1, 32'h7, 0, 0, 0, 4'b0001, 32'h7, 1'b1, 3'd1);
    vecs[5]  = mk(3'd3, 32'h88, 32'h2, 8'd1, 3'd2, 32'hF, 0, 0, 0, 4'b0000, 32'hD, 1'b0, 3'd2);
    vecs[6]  = mk(3'd4, 32'h8C, 32'h1, 8'd0, 3'd3, 32'h0, 32'h0, 32'h1, 0, 4'b0000, 32'h1, 1'b0, 3'd3);
    vecs[7]  = mk(3'd4, 32'h90, 32'h1, 8'd0, 3'd4, 32'h2, 32'h4, 32'h0, 32'h6, 4'b0000, 32'h6, 1'b1, 3'd4);
    vecs[8]  = mk(3'd4, 32'h94, 32'h1, 8'd0, 3'd2, 32'h0, 32'h55, 0, 0, 4'b0010, 32'h55, 1'b1, 3'd2);
    vecs[9]  = mk(3'd5, 32'h98, 32'hFFFF, 8'd0, 3'd0, 0, 0, 0, 0, 4'b0000, 32'h0, 1'b1, 3'd0);
    vecs[10] = mk(3'd0, 32'h9C, 32'hCAFE, 8'd0, 3'd1, 0, 0, 0, 0, 4'b0001, 32'hCAFE, 1'b1, 3'd1);
    vecs[11] = mk(3'd1, 32'hA0, 32'h0, 8'd15, 3'd1, 32'h1357, 0, 0, 0, 4'b0000, 32'h1357, 1'b0, 3'd1);
    vecs[12] = mk(3'd7, 32'hA4, 32'h0, 8'd0, 3'd0, 0, 0, 0, 0, 4'b0000, 32'h0, 1'b1, 3'd0);

    rst_ni = 1'b0; clear_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0;
    cmd_addr_i = '0; cmd_data_i = '0; rsp_ready_i = 1'b0;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("rst_psel", {31'd0, psel_o}, 32'd0);
    check("rst_penable", {31'd0, penable_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // WR launch timing: IDLE during the cycle after the handshake, then SETUP, then ACCESS
    cmd_valid_i = 1'b1; cmd_op_i = 3'd0; cmd_addr_i = 32'h40; cmd_data_i = 32'h1234;
    check("t_accept_ready", {31'd0, cmd_ready_o}, 32'd1);
    exp_q.push_back('{data: 32'h1234, err: 1'b0});
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("t_psel_before", {31'd0, psel_o}, 32'd0);
    @(negedge clk_i);
    check("t_setup_psel", {31'd0, psel_o}, 32'd1);
    check("t_setup_penable", {31'd0, penable_o}, 32'd0);
    check("t_setup_pwrite", {31'd0, pwrite_o}, 32'd1);
    check("t_setup_paddr", paddr_o, 32'h40);
    check("t_setup_pwdata", pwdata_o, 32'h1234);
    @(negedge clk_i);
    check("t_access_psel", {31'd0, psel_o}, 32'd1);
    check("t_access_penable", {31'd0, penable_o}, 32'd1);
    check("t_access_pwdata", pwdata_o, 32'h1234);
    @(negedge clk_i);
    check("t_after_psel", {31'd0, psel_o}, 32'd0);
    check("t_after_paddr", paddr_o, 32'h0);
    check("t_after_pwdata", pwdata_o, 32'h0);
    collect(20);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      xfer_log.delete();
      for (int k = 0; k < int'(v.nslv); k++)
        slv_q.push_back('{waits: v.waits, rdata: v.srd[k], err: v.serr[k]});
      send(v.op, v.addr, v.data, '{data: v.exp_data, err: v.exp_err});
      collect(400);
      check($sformatf("v%0d_xfers", i), xfer_log.size(), {29'd0, v.exp_xfers});
      for (int k = 0; k < xfer_log.size() && k < int'(v.exp_xfers); k++) begin
        is_wr = (v.op == 3'd0) || ((v.op == 3'd2 || v.op == 3'd3) && k == 1);
        check($sformatf("v%0d_x%0d_addr", i, k), xfer_log[k].addr, v.addr);
        check($sformatf("v%0d_x%0d_pwrite", i, k), {31'd0, xfer_log[k].w}, {31'd0, is_wr});
        check($sformatf("v%0d_x%0d_pwdata", i, k), xfer_log[k].wdata, is_wr ? v.exp_data : 32'h0);
      end
      slv_q.delete();
    end

    // Timeout: slave never ready within the 16-cycle window
    pen_cycles = 0;
    xfer_log.delete();
    slv_q.push_back('{waits: 8'd255, rdata: 32'h77, err: 1'b0});
    send(3'd1, 32'hB0, 32'h0, '{data: 32'h0, err: 1'b1});
    collect(400);
    check("tmo_penable_cycles", pen_cycles, 32'd16);
    check("tmo_psel_dropped", {31'd0, psel_o}, 32'd0);
    check("tmo_no_xfer", xfer_log.size(), 32'd0);
    slv_q.delete();

    // FIFO fill with responses blocked, then flush behind the in-flight command
    pen_cycles = 0;
    xfer_log.delete();
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      cmd_valid_i = 1'b1; cmd_op_i = 3'd0;
      cmd_addr_i = 32'h100 + 32'(acc * 4); cmd_data_i = 32'hA000 + 32'(acc);
      ok = cmd_ready_o;
      @(negedge clk_i);
      if (ok) begin
        exp_q.push_back('{data: 32'hA000 + 32'(acc), err: 1'b0});
        acc++;
      end
    end
    check("full_accepted", acc, 32'd9);
    check("full_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    check("full_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    cmd_valid_i = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    check("clr_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("clr_busy_inflight", {31'd0, busy_o}, 32'd1);
    collect(20);
    check("clr_busy_after", {31'd0, busy_o}, 32'd0);
    repeat (10) @(negedge clk_i);
    check("clr_xfers", xfer_log.size(), 32'd1);
    check("clr_pen_cycles", pen_cycles, 32'd1);
    check("clr_rsp_idle", {31'd0, rsp_valid_o}, 32'd0);

    // Reset asserted mid-ACCESS
    slv_q.push_back('{waits: 8'd255, rdata: 32'h0, err: 1'b0});
    cmd_valid_i = 1'b1; cmd_op_i = 3'd1; cmd_addr_i = 32'hC0; cmd_data_i = 32'h0;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("mid_penable", {31'd0, penable_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_psel", {31'd0, psel_o}, 32'd0);
    check("mid_rst_paddr", paddr_o, 32'h0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("mid_rst_err_cnt", {16'd0, err_cnt_o}, 32'd0);
    exp_q.delete();
    slv_q.delete();
    err_exp = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    xfer_log.delete();
    send(3'd0, 32'hC4, 32'h5A5A, '{data: 32'h5A5A, err: 1'b0});
    collect(40);
    check("post_rst_xfers", xfer_log.size(), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sne_apb_cfg_sequencer.md
Name: sne_apb_cfg_sequencer

Overview:
- Synthesizable APB master that executes a queue of configuration commands (write, read, read-modify-set/clear, poll) against the SNE register file.
- Replaces bench-side register programming so on-chip control (uDMA, controller FSM) can program streamers, sequencers, xbar and filters without software.
- Sits between a command stream source and the SNE APB slave port. Read results and errors are returned on a response stream.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; mask width equals DATA_WIDTH.
- FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 1024, maximum ACCESS cycles waiting for pready before abort.
- POLL_MAX, 256, maximum read attempts for a POLL command.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of the command FIFO
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid && ready
- cmd_op_i  in  3  opcode: 0=WR, 1=RD, 2=SET, 3=CLR, 4=POLL; values 5-7 are illegal
- cmd_addr_i  in  ADDR_WIDTH  target register address
- cmd_data_i  in  DATA_WIDTH  WR: data; SET/CLR/POLL: mask
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_data_o  out  DATA_WIDTH  read data, or final written value for WR/SET/CLR
- rsp_err_o  out  1  pslverr, timeout, poll exhaustion or illegal opcode
- busy_o  out  1  FIFO non-empty or FSM not in IDLE
- err_cnt_o  out  16  saturating count of error responses
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  DATA_WIDTH  APB write data
- pwrite_o  out  1  APB write strobe
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Clock/reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset values: all outputs 0 except cmd_ready_o=1. FSM=IDLE, FIFO empty, counters 0.
- FIFO: cmd_ready_o = !full. No bypass, so a push into a full FIFO is impossible. Simultaneous push and pop are allowed at any occupancy below full.
- clear_i empties the FIFO in the same cycle and drops any same-cycle push. An in-flight command still completes and responds.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: if FIFO non-empty, pop the head into the command register and go to SETUP.
  - Illegal opcode: go directly to RESP with err=1, data=0. No APB traffic.
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata valid. Lasts exactly 1 cycle, then ACCESS.
  - ACCESS: psel=1, penable=1. Held until pready_i=1 or timeout.
- APB timing:
  - An accepted command in an idle, empty block raises psel 2 cycles after the handshake edge.
  - A zero-wait-state transfer occupies 2 cycles (SETUP, ACCESS).
  - paddr, pwdata and pwrite are stable from SETUP through the completing ACCESS cycle. They return to 0 when psel drops.
- Timeout: an ACCESS-cycle counter starts at 0 on entering ACCESS. If pready_i is still low when the count equals TIMEOUT_CYCLES-1, drop psel/penable, set err=1, data=0 and go to RESP.
- WR: single write phase; response data = cmd data.
- RD: single read phase; response data = prdata_i captured in the completing cycle.
- SET / CLR:
  - Read phase first. Write value = rdata | mask for SET, rdata & ~mask for CLR.
  - One idle cycle (psel=0) between phases, then a fresh SETUP for the write phase.
  - pslverr in the read phase skips the write phase.
  - Response data = written value.
- POLL:
  - Repeated reads with one idle cycle between them, until (rdata & mask) != 0 gives success with data=rdata.
  - After POLL_MAX failing reads: err=1, data = last rdata.
  - pslverr on any read ends the poll with err=1.
- pslverr_i is sampled only in the completing cycle. It sets err=1, and data=prdata_i for reads.
- RESP: rsp_valid_o=1, with data/err held stable until rsp_ready_i. Leave on the handshake: to IDLE, or to SETUP of the next command on the same edge if the FIFO is non-empty.
- err_cnt_o increments on every response handshake with err=1 and saturates at 0xFFFF.
- Reset asserted mid-transfer: all outputs return immediately to reset values and the FIFO contents are lost.

Decomposition:
- Package sne_cfg_seq_pkg:
  - cfg_op_e enum: WR, RD, SET, CLR, POLL.
  - cfg_cmd_t struct: op, addr, data.
  - cfg_seq_state_e enum.
  - Default width constants.
- Sub-module sne_cfg_cmd_fifo: parametrised synchronous FIFO of cfg_cmd_t, FIFO_DEPTH entries, with push/pop/clear and full/empty flags.

Test Plan:
- WR 0x0000_1234 @0x40, pready=1 -> psel high 2 cycles after accept, SETUP then ACCESS, pwrite=1, pwdata=0x1234; response data=0x1234, err=0.
- SET mask 0x10 @0x80, slave returns 0x0000_0003 with 2 wait states -> second transfer writes 0x13; rsp_data=0x13, err=0.
- CLR mask 0x2 with pslverr on the read -> no write phase issued; rsp_err=1; err_cnt_o=1.
- POLL mask 0x1, POLL_MAX=4, slave returns 0,0,1 -> exactly 3 reads, rsp_data=1, err=0. Slave always returning 0 -> exactly 4 reads, err=1.
- pready held low, TIMEOUT_CYCLES=16 -> penable high exactly 16 cycles then drops; rsp_err=1, rsp_data=0.
- Push 9 commands with FIFO_DEPTH=8 and rsp_ready=0 -> cmd_ready_o low once full. Then clear_i -> in-flight command still responds, no further APB traffic, busy_o falls after the response handshake.
